// File: rtl/mmc1_serial_ctrl.sv
// MMC1 serial register loader and bank mapper: 5-bit shift loads from CPU writes, PRG/CHR/CIRAM/WRAM decode.
// Optional build macro: MMC1_WRAM_DISABLE_EN (prg[4] gates the WRAM chip enable).
module mmc1_serial_ctrl #(
  parameter logic [4:0] CTRL_RESET    = 5'h0C,
  parameter int         FILTER_CONSEC = 1
) (
  input  logic       ck,
  input  logic       nres,
  input  logic       cpu_rw,
  input  logic       cpu_romsel_n,
  input  logic       cpu_a13,
  input  logic       cpu_a14,
  input  logic       cpu_d0,
  input  logic       cpu_d7,
  input  logic       ppu_a10,
  input  logic       ppu_a11,
  input  logic       ppu_a12,
  output logic [3:0] prg_a,
  output logic [4:0] chr_a,
  output logic       ciram_a10,
  output logic       wram_ce_n
);

  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;
  logic [3:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_wr_q, last_wr_d;

  logic       filt_en;
  logic       wr;
  logic       acc;
  logic [4:0] commit_val;
  logic       wram_en;

  assign filt_en = (FILTER_CONSEC != 0);

  // A read-modify-write instruction writes twice in a row; only the first write counts.
  always_comb begin
    wr  = ~cpu_romsel_n & ~cpu_rw;
    acc = wr & ~(filt_en & last_wr_q);
  end

  assign commit_val = {cpu_d0, sr_q};

  always_comb begin
    ctrl_d    = ctrl_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    last_wr_d = wr;
    if (acc) begin
      if (cpu_d7) begin
        sr_d   = 4'h0;
        cnt_d  = 3'd0;
        ctrl_d = ctrl_q | 5'h0C;
      end else if (cnt_q < 3'd4) begin
        sr_d[cnt_q[1:0]] = cpu_d0;
        cnt_d            = cnt_q + 3'd1;
      end else begin
        sr_d  = 4'h0;
        cnt_d = 3'd0;
        case ({cpu_a14, cpu_a13})
          2'b00:   ctrl_d = commit_val;
          2'b01:   chr0_d = commit_val;
          2'b10:   chr1_d = commit_val;
          default: prg_d  = commit_val;
        endcase
      end
    end
  end

  always_ff @(posedge ck) begin
    if (!nres) begin
      ctrl_q    <= CTRL_RESET;
      chr0_q    <= 5'h00;
      chr1_q    <= 5'h00;
      prg_q     <= 5'h00;
      sr_q      <= 4'h0;
      cnt_q     <= 3'd0;
      last_wr_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
    end
  end

`ifdef MMC1_WRAM_DISABLE_EN
  assign wram_en = ~prg_q[4];
`else
  logic prg4_unused;
  assign prg4_unused = prg_q[4];
  assign wram_en     = 1'b1;
`endif

  always_comb begin
    case (ctrl_q[1:0])
      2'd0:    ciram_a10 = 1'b0;
      2'd1:    ciram_a10 = 1'b1;
      2'd2:    ciram_a10 = ppu_a10;
      default: ciram_a10 = ppu_a11;
    endcase

    // Modes 2/3 fix one 16K half and switch the other; modes 0/1 switch 32K.
    case (ctrl_q[3:2])
      2'd2:    prg_a = cpu_a14 ? prg_q[3:0] : 4'h0;
      2'd3:    prg_a = cpu_a14 ? 4'hF : prg_q[3:0];
      default: prg_a = {prg_q[3:1], cpu_a14};
    endcase

    if (ctrl_q[4]) chr_a = ppu_a12 ? chr1_q : chr0_q;
    else           chr_a = {chr0_q[4:1], ppu_a12};

    wram_ce_n = ~(cpu_romsel_n & cpu_a14 & cpu_a13 & wram_en);
  end

endmodule

// File: tb/tb_mmc1_serial_ctrl.sv
// Table-driven bench for mmc1_serial_ctrl; expected outputs queued at drive time, compared after the edge.
// Honours MMC1_WRAM_DISABLE_EN for the WRAM enable expectation.
module tb_mmc1_serial_ctrl;

  logic       ck = 1'b0;
  logic       nres, cpu_rw, cpu_romsel_n, cpu_a13, cpu_a14, cpu_d0, cpu_d7;
  logic       ppu_a10, ppu_a11, ppu_a12;
  logic [3:0] prg_a;
  logic [4:0] chr_a;
  logic       ciram_a10, wram_ce_n;

  always #5 ck = ~ck;

  mmc1_serial_ctrl dut (
    .ck(ck), .nres(nres), .cpu_rw(cpu_rw), .cpu_romsel_n(cpu_romsel_n),
    .cpu_a13(cpu_a13), .cpu_a14(cpu_a14), .cpu_d0(cpu_d0), .cpu_d7(cpu_d7),
    .ppu_a10(ppu_a10), .ppu_a11(ppu_a11), .ppu_a12(ppu_a12),
    .prg_a(prg_a), .chr_a(chr_a), .ciram_a10(ciram_a10), .wram_ce_n(wram_ce_n)
  );

`ifdef MMC1_WRAM_DISABLE_EN
  localparam logic WRAM_DIS = 1'b1;
`else
  localparam logic WRAM_DIS = 1'b0;
`endif

  typedef struct {
    logic        nres, rw, romsel_n, a14, a13, d0, d7, p10, p11, p12;
    logic        chk;
    logic [10:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [10:0] ex(input logic [3:0] p, input logic [4:0] c,
                                     input logic ci, input logic w);
    return {p, c, ci, w};
  endfunction

  function automatic vec_t idle(input logic a14, input logic a13, input logic p10,
                                input logic p11, input logic p12);
    vec_t r;
    r.nres = 1'b1; r.rw = 1'b1; r.romsel_n = 1'b1; r.a14 = a14; r.a13 = a13;
    r.d0 = 1'b0; r.d7 = 1'b0; r.p10 = p10; r.p11 = p11; r.p12 = p12;
    r.chk = 1'b0; r.exp = '0;
    return r;
  endfunction

  function automatic vec_t wrv(input logic a14, input logic a13, input logic d0, input logic d7);
    vec_t r;
    r = idle(a14, a13, 1'b0, 1'b0, 1'b0);
    r.rw = 1'b0; r.romsel_n = 1'b0; r.d0 = d0; r.d7 = d7;
    return r;
  endfunction

  function automatic vec_t chkd(input vec_t r, input logic [10:0] e);
    vec_t o;
    o = r; o.chk = 1'b1; o.exp = e;
    return o;
  endfunction

  // Reset cycle carrying a write, so reset priority is exercised too.
  function automatic vec_t rstv();
    vec_t r;
    r = wrv(1'b1, 1'b1, 1'b1, 1'b0);
    r.nres = 1'b0;
    return chkd(r, ex(4'hF, 5'h00, 1'b0, 1'b1));
  endfunction

  task automatic add_wr(input logic a14, input logic a13, input logic d0, input logic d7);
    tbl.push_back(wrv(a14, a13, d0, d7));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic add_val(input logic a14, input logic a13, input logic [4:0] v);
    for (int i = 0; i < 5; i++) add_wr(a14, a13, v[i], 1'b0);
  endtask

  task automatic apply_row(input vec_t r, input int idx);
    logic [10:0] e, got;
    @(negedge ck);
    nres = r.nres; cpu_rw = r.rw; cpu_romsel_n = r.romsel_n; cpu_a14 = r.a14;
    cpu_a13 = r.a13; cpu_d0 = r.d0; cpu_d7 = r.d7;
    ppu_a10 = r.p10; ppu_a11 = r.p11; ppu_a12 = r.p12;
    if (r.chk) exp_q.push_back(r.exp);
    @(posedge ck);
    #1;
    if (r.chk) begin
      e   = exp_q.pop_front();
      got = {prg_a, chr_a, ciram_a10, wram_ce_n};
      n_total++;
      if (got === e) n_pass++;
      else $display("FAIL row%0d outputs: got prg_a=%h chr_a=%h ciram_a10=%b wram_ce_n=%b, expected prg_a=%h chr_a=%h ciram_a10=%b wram_ce_n=%b",
                    idx, got[10:7], got[6:2], got[1], got[0], e[10:7], e[6:2], e[1], e[0]);
    end
  endtask

  initial begin
    nres = 1'b0; cpu_rw = 1'b1; cpu_romsel_n = 1'b1; cpu_a14 = 1'b0; cpu_a13 = 1'b0;
    cpu_d0 = 1'b0; cpu_d7 = 1'b0; ppu_a10 = 1'b0; ppu_a11 = 1'b0; ppu_a12 = 1'b0;

    // Reset state
    tbl.push_back(rstv());
    tbl.push_back(rstv());
    tbl.push_back(chkd(idle(1, 0, 0, 0, 1), ex(4'hF, 5'h01, 1'b0, 1'b1)));
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'h0, 5'h00, 1'b0, 1'b1)));

    // prg = 05, visible one cycle after the fifth write
    add_wr(1, 1, 1, 0); add_wr(1, 1, 0, 0); add_wr(1, 1, 1, 0); add_wr(1, 1, 0, 0);
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'h0, 5'h00, 1'b0, 1'b1)));
    tbl.push_back(wrv(1, 1, 0, 0));
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'h5, 5'h00, 1'b0, 1'b1)));
    tbl.push_back(chkd(idle(1, 1, 0, 0, 0), ex(4'hF, 5'h00, 1'b0, 1'b0)));

    // Partial chr0 load, D7 reset, then chr0 = 1F
    add_wr(0, 1, 0, 0); add_wr(0, 1, 1, 0); add_wr(0, 1, 0, 0);
    add_wr(0, 1, 0, 1);
    add_val(0, 1, 5'h1F);
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'h5, 5'h1E, 1'b0, 1'b1)));
    tbl.push_back(chkd(idle(0, 0, 0, 0, 1), ex(4'h5, 5'h1F, 1'b0, 1'b1)));

    // Back-to-back write counts once: bits 1,0,1,1,0 -> prg = 0D
    tbl.push_back(wrv(1, 1, 1, 0));
    tbl.push_back(wrv(1, 1, 1, 0));
    tbl.push_back(idle(0, 0, 0, 0, 0));
    add_wr(1, 1, 0, 0); add_wr(1, 1, 1, 0); add_wr(1, 1, 1, 0);
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'h5, 5'h1E, 1'b0, 1'b1)));
    add_wr(1, 1, 0, 0);
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'hD, 5'h1E, 1'b0, 1'b1)));

    // chr0 = 02, chr1 = 07, ctrl = 13
    add_val(0, 1, 5'h02); add_val(1, 0, 5'h07); add_val(0, 0, 5'h13);
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'hC, 5'h02, 1'b0, 1'b1)));
    tbl.push_back(chkd(idle(0, 0, 0, 1, 1), ex(4'hC, 5'h07, 1'b1, 1'b1)));
    tbl.push_back(chkd(idle(0, 0, 1, 0, 0), ex(4'hC, 5'h02, 1'b0, 1'b1)));
    tbl.push_back(chkd(idle(1, 0, 0, 0, 1), ex(4'hD, 5'h07, 1'b0, 1'b1)));

    // D7 write ORs 0C into ctrl: 13 -> 1F
    add_wr(0, 0, 1, 1);
    tbl.push_back(chkd(idle(0, 0, 0, 1, 1), ex(4'hD, 5'h07, 1'b1, 1'b1)));
    tbl.push_back(chkd(idle(1, 0, 0, 0, 0), ex(4'hF, 5'h02, 1'b0, 1'b1)));

    // Reset mid-sequence discards partial bits; then prg = 10
    add_wr(1, 1, 1, 0); add_wr(1, 1, 1, 0);
    tbl.push_back(rstv());
    tbl.push_back(idle(0, 0, 0, 0, 0));
    add_val(1, 1, 5'h10);
    tbl.push_back(chkd(idle(1, 1, 0, 0, 0), ex(4'hF, 5'h00, 1'b0, WRAM_DIS)));
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'h0, 5'h00, 1'b0, 1'b1)));

    // ctrl = 0A (mirroring from ppu_a10, PRG mode 2), then 0D (single-screen 1)
    add_val(0, 0, 5'h0A);
    tbl.push_back(chkd(idle(1, 0, 1, 0, 0), ex(4'h0, 5'h00, 1'b1, 1'b1)));
    tbl.push_back(chkd(idle(0, 0, 0, 1, 0), ex(4'h0, 5'h00, 1'b0, 1'b1)));
    add_val(0, 0, 5'h0D);
    tbl.push_back(chkd(idle(0, 0, 0, 0, 0), ex(4'h0, 5'h00, 1'b1, 1'b1)));

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

    // Sustained three-cycle write accepts one bit; ctrl = bits 0,1,0,0,0 = 02
    apply_row(wrv(0, 0, 0, 0), 1000);
    apply_row(wrv(0, 0, 0, 0), 1001);
    apply_row(wrv(0, 0, 0, 0), 1002);
    apply_row(idle(0, 0, 0, 0, 0), 1003);
    apply_row(wrv(0, 0, 1, 0), 1004); apply_row(idle(0, 0, 0, 0, 0), 1005);
    apply_row(wrv(0, 0, 0, 0), 1006); apply_row(idle(0, 0, 0, 0, 0), 1007);
    apply_row(wrv(0, 0, 0, 0), 1008); apply_row(idle(0, 0, 0, 0, 0), 1009);
    apply_row(wrv(0, 0, 0, 0), 1010);
    apply_row(chkd(idle(1, 0, 1, 0, 0), ex(4'h1, 5'h00, 1'b1, 1'b1)), 1011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
